// File: rtl/alu_regfile_if.sv
// Operand/writeback bus between the ALU datapath and its register file.
// master = ALU/controller side, slave = register file side.
interface alu_regfile_if #(
    parameter int BITSIZE = 64,
    parameter int ADDRW   = 5,
    parameter int CNTW    = 8
);
    logic               rd_en;
    logic [ADDRW-1:0]   rd_addr1;
    logic [ADDRW-1:0]   rd_addr2;
    logic [BITSIZE-1:0] data1;
    logic [BITSIZE-1:0] data2;
    logic               rd_valid;
    logic               wr_en;
    logic [ADDRW-1:0]   wr_addr;
    logic [BITSIZE-1:0] aluout;
    logic               flagz;
    logic               zflag_q;
    logic [CNTW-1:0]    wr_count;

    modport master (
        output rd_en, rd_addr1, rd_addr2,
        output wr_en, wr_addr, aluout, flagz,
        input  data1, data2, rd_valid,
        input  zflag_q, wr_count
    );

    modport slave (
        input  rd_en, rd_addr1, rd_addr2,
        input  wr_en, wr_addr, aluout, flagz,
        output data1, data2, rd_valid,
        output zflag_q, wr_count
    );
endinterface

// File: rtl/alu_regfile.sv
// ALU operand register file: registered dual read with write-first
// bypass, r0 hardwired to zero, sticky zero flag and writeback counter.
module alu_regfile #(
    parameter int BITSIZE = 64,
    parameter int REGSIZE = 32,
    parameter int ADDRW   = 5,
    parameter int CNTW    = 8
) (
    input logic          clk,
    input logic          rst,
    alu_regfile_if.slave bus
);

    logic [BITSIZE-1:0] regs [REGSIZE];
    logic [BITSIZE-1:0] val1;
    logic [BITSIZE-1:0] val2;
    logic               wr_ok;

    function automatic logic in_range(input logic [ADDRW-1:0] a);
        return {{(32-ADDRW){1'b0}}, a} < 32'(REGSIZE);
    endfunction

    // Write is accepted only for a real, in-range, non-zero register.
    always_comb begin
        wr_ok = bus.wr_en && (bus.wr_addr != '0) && in_range(bus.wr_addr);
    end

    // Read port 1 value: zero for r0/out-of-range, else bypass, else array.
    always_comb begin
        val1 = '0;
        if (bus.rd_addr1 != '0 && in_range(bus.rd_addr1)) begin
            if (bus.wr_en && bus.wr_addr == bus.rd_addr1)
                val1 = bus.aluout;
            else
                val1 = regs[bus.rd_addr1];
        end
    end

    // Read port 2 value, resolved independently of port 1.
    always_comb begin
        val2 = '0;
        if (bus.rd_addr2 != '0 && in_range(bus.rd_addr2)) begin
            if (bus.wr_en && bus.wr_addr == bus.rd_addr2)
                val2 = bus.aluout;
            else
                val2 = regs[bus.rd_addr2];
        end
    end

    // Register array: clear on reset, capture ALU writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REGSIZE; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.aluout;
        end
    end

    // Operand outputs: load on read, hold otherwise; valid pulses one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data1    <= '0;
            bus.data2    <= '0;
            bus.rd_valid <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                bus.data1 <= val1;
                bus.data2 <= val2;
            end
        end
    end

    // Zero flag follows every writeback strobe, including r0 compare-only ops.
    always_ff @(posedge clk) begin
        if (rst)
            bus.zflag_q <= 1'b0;
        else if (bus.wr_en)
            bus.zflag_q <= bus.flagz;
    end

    // Count accepted writes; wraps naturally at 2^CNTW.
    always_ff @(posedge clk) begin
        if (rst)
            bus.wr_count <= '0;
        else if (wr_ok)
            bus.wr_count <= bus.wr_count + CNTW'(1);
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: reset, read/write, bypass, r0,
// counter wrap, reset priority and operand hold.
module tb_alu_regfile;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    alu_regfile_if bus ();

    alu_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.flagz    = 1'b0;
        bus.aluout   = '0;
        bus.wr_addr  = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] v,
                      input logic z);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.aluout  = v;
        bus.flagz   = z;
        step();
        idle();
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.rd_en    = 1'b1;
        bus.rd_addr1 = a1;
        bus.rd_addr2 = a2;
        step();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_data1", bus.data1, 64'd0);
        check("rst_data2", bus.data2, 64'd0);
        check("rst_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("rst_zflag", {63'd0, bus.zflag_q}, 64'd0);
        check("rst_count", {56'd0, bus.wr_count}, 64'd0);

        // 1: fill, reset, all read back zero
        for (int i = 1; i < 32; i++)
            wr(5'(i), 64'h1111 * 64'(i), 1'b1);
        check("fill_count", {56'd0, bus.wr_count}, 64'd31);
        check("fill_zflag", {63'd0, bus.zflag_q}, 64'd1);
        rd(5'd7, 5'd31);
        check("fill_r7", bus.data1, 64'h7777);
        check("fill_r31", bus.data2, 64'h1111 * 64'd31);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_zflag", {63'd0, bus.zflag_q}, 64'd0);
        check("rst2_count", {56'd0, bus.wr_count}, 64'd0);
        for (int i = 1; i < 32; i++) begin
            rd(5'(i), 5'(32 - i));
            check($sformatf("rst_rd1_r%0d", i), bus.data1, 64'd0);
            check($sformatf("rst_rd2_r%0d", i), bus.data2, 64'd0);
            check($sformatf("rst_rv_r%0d", i),
                  {63'd0, bus.rd_valid}, 64'd1);
        end

        // 2: write then read
        wr(5'd3, 64'b1101, 1'b0);
        wr(5'd4, 64'b01, 1'b0);
        rd(5'd3, 5'd4);
        check("wr_data1", bus.data1, 64'd13);
        check("wr_data2", bus.data2, 64'd1);
        check("wr_valid", {63'd0, bus.rd_valid}, 64'd1);
        check("wr_count2", {56'd0, bus.wr_count}, 64'd2);

        // 3: bypass on both ports, then one port only
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd5;
        bus.aluout  = 64'd14;
        rd(5'd5, 5'd5);
        idle();
        check("byp_data1", bus.data1, 64'd14);
        check("byp_data2", bus.data2, 64'd14);
        rd(5'd5, 5'd3);
        check("byp_later", bus.data1, 64'd14);
        check("byp_other", bus.data2, 64'd13);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd6;
        bus.aluout  = 64'hAB;
        rd(5'd5, 5'd6);
        idle();
        check("byp2_data1", bus.data1, 64'd14);
        check("byp2_data2", bus.data2, 64'hAB);
        check("byp_count", {56'd0, bus.wr_count}, 64'd4);

        // 4: r0 discard, flag still updates
        wr(5'd0, 64'hFFFF, 1'b1);
        check("r0_zflag", {63'd0, bus.zflag_q}, 64'd1);
        check("r0_count", {56'd0, bus.wr_count}, 64'd4);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd0;
        bus.aluout  = 64'hDEAD;
        bus.flagz   = 1'b1;
        rd(5'd0, 5'd0);
        idle();
        check("r0_byp1", bus.data1, 64'd0);
        check("r0_byp2", bus.data2, 64'd0);
        rd(5'd0, 5'd3);
        check("r0_read", bus.data1, 64'd0);
        wr(5'd2, 64'd7, 1'b0);
        check("r2_zflag", {63'd0, bus.zflag_q}, 64'd0);
        check("r2_count", {56'd0, bus.wr_count}, 64'd5);

        // 6: hold with rd_en low
        rd(5'd3, 5'd4);
        check("hold_pre", bus.data1, 64'd13);
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_d1_%0d", i), bus.data1, 64'd13);
            check($sformatf("hold_d2_%0d", i), bus.data2, 64'd1);
            check($sformatf("hold_rv_%0d", i),
                  {63'd0, bus.rd_valid}, 64'd0);
        end

        // 5: counter wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 255; i++)
            wr(5'd1, 64'(i), 1'b0);
        check("cnt_255", {56'd0, bus.wr_count}, 64'd255);
        wr(5'd0, 64'd1, 1'b0);
        check("cnt_r0", {56'd0, bus.wr_count}, 64'd255);
        wr(5'd1, 64'd99, 1'b0);
        check("cnt_wrap", {56'd0, bus.wr_count}, 64'd0);

        // 5: reset wins over same-cycle write and read
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.aluout  = 64'd9;
        bus.flagz   = 1'b1;
        rd(5'd7, 5'd1);
        rst = 1'b0;
        idle();
        check("pri_data1", bus.data1, 64'd0);
        check("pri_valid", {63'd0, bus.rd_valid}, 64'd0);
        check("pri_zflag", {63'd0, bus.zflag_q}, 64'd0);
        check("pri_count", {56'd0, bus.wr_count}, 64'd0);
        rd(5'd7, 5'd1);
        check("pri_r7", bus.data1, 64'd0);
        check("pri_r1", bus.data2, 64'd0);
        check("pri_rv", {63'd0, bus.rd_valid}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
